reaction_ctrl: RTL and testbench

//  Reaction-timer control FSM, upstream of the seven-segment output mux.

---
 rtl/reaction_ctrl_pkg.sv | 24 ++
 rtl/reaction_ctrl_bcd_counter4.sv | 49 ++++
 rtl/reaction_ctrl.sv | 181 ++++++++++++++++++
 tb/tb_reaction_ctrl.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/reaction_ctrl_pkg.sv
// Shared definitions for the reaction timer: display-state codes, BCD limits
// and small helpers used by the controller and its BCD counter.
package reaction_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_TIMING = 2'd2,
        ST_DONE   = 2'd3
    } state_t;

    localparam logic [15:0] BCD_MAX = 16'h9999;

    // Packed BCD orders exactly like unsigned binary, thousands digit first.
    function automatic logic bcd_less(input logic [15:0] a, input logic [15:0] b);
        return a < b;
    endfunction

    // 16-bit Fibonacci LFSR, taps 16,14,13,11.
    function automatic logic [15:0] lfsr_step(input logic [15:0] v);
        return {v[14:0], v[15] ^ v[13] ^ v[12] ^ v[10]};
    endfunction

endpackage

// File: rtl/reaction_ctrl_bcd_counter4.sv
// Four-digit BCD up-counter with synchronous clear, load-to-max, enable,
// saturation at 9999 and a max flag.
module bcd_counter4
    import reaction_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clr,
    input  logic        set_max,
    input  logic        en,
    output logic [15:0] count,
    output logic        at_max
);

    logic [15:0] count_reg;
    logic [15:0] count_next;
    logic [3:0]  carry;

    assign at_max   = (count_reg == BCD_MAX);
    assign carry[0] = en & ~at_max;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_digit
            logic [3:0] digit;
            assign digit = count_reg[4*gi +: 4];
            assign count_next[4*gi +: 4] = !carry[gi]     ? digit :
                                           (digit == 4'd9) ? 4'd0  : digit + 4'd1;
            if (gi < 3) begin : g_carry
                assign carry[gi+1] = carry[gi] & (digit == 4'd9);
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= 16'h0000;
        end else if (clr) begin
            count_reg <= 16'h0000;
        end else if (set_max) begin
            count_reg <= BCD_MAX;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count = count_reg;

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer controller: random blank wait, millisecond BCD timing of the
// reaction press, false-start detection and a volatile best-time register.
module reaction_ctrl
    import reaction_ctrl_pkg::*;
#(
    parameter int          CLK_HZ          = 50_000_000,
    parameter int          DELAY_MIN_MS    = 1000,
    parameter int          DELAY_SPAN_BITS = 11,
    parameter logic [15:0] LFSR_SEED       = 16'hACE1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start_btn,
    input  logic        react_btn,
    output logic [1:0]  state,
    output logic [15:0] bcd_time,
    output logic [15:0] bcd_high,
    output logic        early,
    output logic        new_high
);

    localparam int TICK_DIV = CLK_HZ / 1000;
    localparam int TICK_W   = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int WAIT_MAX = DELAY_MIN_MS + (1 << DELAY_SPAN_BITS) - 1;
    localparam int WAIT_W   = (WAIT_MAX > 0) ? $clog2(WAIT_MAX + 1) : 1;
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);

    // Button conditioning: two-flop synchronizer plus one history flop per pin.
    logic [1:0] pin_vec;
    logic [1:0] sync1_reg, sync2_reg, hist_reg;
    logic       start_edge, react_edge;

    assign pin_vec = {react_btn, start_btn};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= 2'b00;
            sync2_reg <= 2'b00;
            hist_reg  <= 2'b00;
        end else begin
            sync1_reg <= pin_vec;
            sync2_reg <= sync1_reg;
            hist_reg  <= sync2_reg;
        end
    end

    assign start_edge = sync2_reg[0] & ~hist_reg[0];
    assign react_edge = sync2_reg[1] & ~hist_reg[1];

    logic [15:0] lfsr_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lfsr_reg <= LFSR_SEED;
        end else begin
            lfsr_reg <= lfsr_step(lfsr_reg);
        end
    end

    state_t              state_reg, state_next;
    logic [TICK_W-1:0]   tick_reg;
    logic                tick;
    logic [WAIT_W-1:0]   wait_reg;
    logic                early_reg, new_high_reg, judge_reg;
    logic [15:0]         high_reg;
    logic                enter_wait, false_start, count_en, state_change;
    logic [15:0]         count;
    logic                count_at_max;

    assign tick         = (tick_reg == TICK_LAST);
    assign state_change = (state_next != state_reg);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // A react edge always beats a coincident tick or start edge while a run is live.
    always_comb begin
        state_next  = state_reg;
        enter_wait  = 1'b0;
        false_start = 1'b0;
        count_en    = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                if (start_edge) begin
                    state_next = ST_WAIT;
                    enter_wait = 1'b1;
                end
            end
            ST_WAIT: begin
                if (react_edge) begin
                    state_next  = ST_DONE;
                    false_start = 1'b1;
                end else if (tick && (wait_reg <= WAIT_W'(1))) begin
                    state_next = ST_TIMING;
                end
            end
            ST_TIMING: begin
                if (react_edge || count_at_max) begin
                    state_next = ST_DONE;
                end else begin
                    count_en = tick;
                end
            end
            ST_DONE: begin
                if (start_edge) begin
                    state_next = ST_WAIT;
                    enter_wait = 1'b1;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // Millisecond divider restarts on every state entry so each phase is whole ms.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tick_reg <= '0;
        end else if (state_change || tick) begin
            tick_reg <= '0;
        end else begin
            tick_reg <= tick_reg + TICK_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wait_reg <= '0;
        end else if (enter_wait) begin
            wait_reg <= WAIT_W'(DELAY_MIN_MS) + WAIT_W'(lfsr_reg[DELAY_SPAN_BITS-1:0]);
        end else if ((state_reg == ST_WAIT) && tick && (wait_reg != '0)) begin
            wait_reg <= wait_reg - WAIT_W'(1);
        end
    end

    bcd_counter4 u_counter (
        .clk     (clk),
        .rst_n   (rst_n),
        .clr     (enter_wait),
        .set_max (false_start),
        .en      (count_en),
        .count   (count),
        .at_max  (count_at_max)
    );

    // Best-time judgement runs on the first DONE cycle, once bcd_time is frozen.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            early_reg    <= 1'b0;
            new_high_reg <= 1'b0;
            judge_reg    <= 1'b0;
            high_reg     <= BCD_MAX;
        end else begin
            judge_reg <= (state_next == ST_DONE) && (state_reg != ST_DONE);
            if (enter_wait) begin
                early_reg <= 1'b0;
            end else if (false_start) begin
                early_reg <= 1'b1;
            end
            if (judge_reg && !early_reg && !count_at_max && bcd_less(count, high_reg)) begin
                high_reg <= count;
            end
            if (enter_wait) begin
                new_high_reg <= 1'b0;
            end else if (judge_reg && !early_reg && !count_at_max && bcd_less(count, high_reg)) begin
                new_high_reg <= 1'b1;
            end
        end
    end

    assign state    = state_reg;
    assign bcd_time = count;
    assign bcd_high = high_reg;
    assign early    = early_reg;
    assign new_high = new_high_reg;

endmodule

// File: tb/tb_reaction_ctrl.sv
// Directed-plus-random bench for reaction_ctrl with a 4-clock ms tick; expected
// values come from millisecond arithmetic and a software LFSR.
module tb_reaction_ctrl;

    localparam int DMIN = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start_btn = 1'b0;
    logic        react_btn = 1'b0;
    logic [1:0]  state;
    logic [15:0] bcd_time;
    logic [15:0] bcd_high;
    logic        early;
    logic        new_high;

    int checks = 0;
    int errors = 0;
    int high_ms = 9999;
    logic [15:0] m_lfsr;

    reaction_ctrl #(
        .CLK_HZ          (4000),
        .DELAY_MIN_MS    (DMIN),
        .DELAY_SPAN_BITS (2),
        .LFSR_SEED       (16'hACE1)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start_btn (start_btn),
        .react_btn (react_btn),
        .state     (state),
        .bcd_time  (bcd_time),
        .bcd_high  (bcd_high),
        .early     (early),
        .new_high  (new_high)
    );

    always #5 clk = ~clk;

    // Reference LFSR: one shift per clock, taps 16,14,13,11.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 16'hACE1;
        else        m_lfsr <= {m_lfsr[14:0], m_lfsr[15] ^ m_lfsr[13] ^ m_lfsr[12] ^ m_lfsr[10]};
    end

    function automatic logic [15:0] to_bcd(input int v);
        return {4'(v / 1000 % 10), 4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Returns the expected wait in ms, computed from the LFSR value the DUT samples.
    task automatic press_start(output int w);
        step($urandom_range(2, 15));
        start_btn = 1'b1;
        step(2);
        w = DMIN + int'(m_lfsr[1:0]);
        step(1);
        start_btn = 1'b0;
        check("wait_entry_state", 16'(state), 16'd1);
        check("wait_entry_time", bcd_time, 16'h0000);
        check("wait_entry_early", 16'(early), 16'd0);
        check("wait_entry_newhigh", 16'(new_high), 16'd0);
        check("wait_entry_high", bcd_high, to_bcd(high_ms));
    endtask

    task automatic wait_to_timing(input int w);
        step(4 * w - 1);
        check("wait_hold", 16'(state), 16'd1);
        step(1);
        check("timing_entry", 16'(state), 16'd2);
        check("timing_entry_time", bcd_time, 16'h0000);
    endtask

    // Raise react just after TIMING edge p; it acts 3 clocks later, so the
    // frozen count is every tick strictly before that edge: (p+2)/4 ms.
    task automatic react_at(input int p, input int elapsed, input bit with_start);
        int  v;
        bit  nh;
        step(p - elapsed);
        react_btn = 1'b1;
        if (with_start) start_btn = 1'b1;
        step(3);
        react_btn = 1'b0;
        start_btn = 1'b0;
        v = (p + 2) / 4;
        check("react_state", 16'(state), 16'd3);
        check("react_time", bcd_time, to_bcd(v));
        check("react_early", 16'(early), 16'd0);
        step(1);
        nh = (v < high_ms);
        if (nh) high_ms = v;
        check("react_newhigh", 16'(new_high), 16'(nh));
        check("react_high", bcd_high, to_bcd(high_ms));
        $display("run: reaction %0d ms, best %0d ms, new_high=%0d", v, high_ms, new_high);
    endtask

    initial begin
        int w;
        int p;
        int n;

        // Reset values
        step(2);
        check("rst_state", 16'(state), 16'd0);
        check("rst_time", bcd_time, 16'h0000);
        check("rst_high", bcd_high, 16'h9999);
        check("rst_early", 16'(early), 16'd0);
        check("rst_newhigh", 16'(new_high), 16'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step(1);
            check("idle_hold", 16'(state), 16'd0);
        end

        // First run: count checked every ms, react lands on the tick of ms 38
        press_start(w);
        wait_to_timing(w);
        for (int k = 1; k <= 37; k++) begin
            step(4);
            check("count_step", bcd_time, to_bcd(k));
        end
        react_at(149, 148, 1'b0);

        // Equal time is not a new best
        press_start(w);
        wait_to_timing(w);
        react_at(149, 0, 1'b0);

        // False start during WAIT
        press_start(w);
        react_btn = 1'b1;
        step(3);
        react_btn = 1'b0;
        check("fs_state", 16'(state), 16'd3);
        check("fs_early", 16'(early), 16'd1);
        check("fs_time", bcd_time, 16'h9999);
        check("fs_high", bcd_high, to_bcd(high_ms));
        step(1);
        check("fs_newhigh", 16'(new_high), 16'd0);
        check("fs_high_after", bcd_high, to_bcd(high_ms));
        $display("run: false start, best %0d ms", high_ms);

        // Random reaction times
        for (int i = 0; i < 5; i++) begin
            press_start(w);
            wait_to_timing(w);
            react_at($urandom_range(4, 240), 0, 1'b0);
        end

        // Start and react together in TIMING: react wins, start is dropped
        press_start(w);
        wait_to_timing(w);
        p = $urandom_range(20, 60);
        react_at(p, 0, 1'b1);
        step(4);
        check("both_stay_done", 16'(state), 16'd3);

        // Timeout: no react, full count to 9999 with every carry checked
        press_start(w);
        wait_to_timing(w);
        for (int k = 1; k <= 9999; k++) begin
            step(4);
            check("timeout_count", bcd_time, to_bcd(k));
        end
        n = 0;
        while (state !== 2'd3 && n < 8) begin
            step(1);
            n++;
        end
        check("timeout_state", 16'(state), 16'd3);
        check("timeout_time", bcd_time, 16'h9999);
        check("timeout_early", 16'(early), 16'd0);
        step(1);
        check("timeout_newhigh", 16'(new_high), 16'd0);
        check("timeout_high", bcd_high, to_bcd(high_ms));
        $display("run: timeout at 9999, best %0d ms", high_ms);

        // Asynchronous reset in the middle of TIMING
        press_start(w);
        wait_to_timing(w);
        step(10);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        high_ms = 9999;
        check("midrst_state", 16'(state), 16'd0);
        check("midrst_time", bcd_time, 16'h0000);
        check("midrst_high", bcd_high, 16'h9999);
        check("midrst_early", 16'(early), 16'd0);
        check("midrst_newhigh", 16'(new_high), 16'd0);
        step(2);
        @(negedge clk);
        rst_n = 1'b1;
        step(5);
        check("post_rst_idle", 16'(state), 16'd0);
        $display("run: reset during timing");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
